ntt_butterfly_scheduler: RTL and testbench

//  Sequencer that sits directly upstream of the butterfly unit and also takes its results. Walks all
//  7 Kyber forward-NTT layers (Cooley-Tukey, len 128..2) over a 256-coefficient dual-port RAM. Reads

---
 rtl/ntt_pkg.sv | 24 ++
 rtl/ntt_addr_fifo.sv | 53 +++++
 rtl/ntt_butterfly_scheduler.sv | 167 ++++++++++++++++
 tb/tb_ntt_butterfly_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and types for the Kyber forward-NTT butterfly scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package ntt_pkg;
    localparam int DATA_WIDTH    = 12;
    localparam int N             = 256;
    localparam int ADDR_WIDTH    = 8;
    localparam int TW_ADDR_WIDTH = 7;
    localparam int NUM_LAYERS    = 7;
    localparam int LAYER_W       = 3;
    localparam int KYBER_Q       = 3329;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] a;
        logic [ADDR_WIDTH-1:0] b;
    } addr_pair_t;
endpackage

// File: rtl/ntt_addr_fifo.sv
// Write-back address FIFO; its occupancy is the butterfly in-flight count.
// Latency: pushed entry visible at the head the cycle after push (show-ahead read).
// Backpressure: caller must not push when full_o; pop is ignored when empty_o.
module ntt_addr_fifo
    import ntt_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  addr_pair_t       push_dat_i,
    input  logic             pop_i,
    output addr_pair_t       pop_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    addr_pair_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    assign do_pop = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
endmodule

// File: rtl/ntt_butterfly_scheduler.sv
// Kyber forward-NTT sequencer: issues coefficient pairs + twiddle, writes results back; NTT_CYCLE_COUNT_EN adds cycle_count_o.
// Latency: read issued combinationally in ISSUE; write-back in the same cycle as bf_valid_out_i.
// Backpressure: issue stalls while FIFO_DEPTH butterflies are in flight; layers are barriered in DRAIN.
module ntt_butterfly_scheduler
    import ntt_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     rd_en_o,
    output logic [ADDR_WIDTH-1:0]    rd_addr_a_o,
    output logic [ADDR_WIDTH-1:0]    rd_addr_b_o,
    input  logic [DATA_WIDTH-1:0]    rd_data_a_i,
    input  logic [DATA_WIDTH-1:0]    rd_data_b_i,
    output logic [TW_ADDR_WIDTH-1:0] tw_addr_o,
    input  logic [DATA_WIDTH-1:0]    tw_data_i,
    output logic                     bf_enable_o,
    output logic                     bf_valid_in_o,
    output logic [DATA_WIDTH-1:0]    bf_a_o,
    output logic [DATA_WIDTH-1:0]    bf_b_o,
    output logic [DATA_WIDTH-1:0]    bf_twiddle_o,
    input  logic                     bf_valid_out_i,
    input  logic [DATA_WIDTH-1:0]    bf_a_out_i,
    input  logic [DATA_WIDTH-1:0]    bf_b_out_i,
    output logic                     wr_en_o,
    output logic [ADDR_WIDTH-1:0]    wr_addr_a_o,
    output logic [ADDR_WIDTH-1:0]    wr_addr_b_o,
    output logic [DATA_WIDTH-1:0]    wr_data_a_o,
    output logic [DATA_WIDTH-1:0]    wr_data_b_o,
    output logic                     err_underflow_o
`ifdef NTT_CYCLE_COUNT_EN
    ,
    output logic [31:0]              cycle_count_o
`endif
);
    localparam int P_W   = ADDR_WIDTH - 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [P_W-1:0]     p_q, p_d;
    logic               bf_vld_q, err_q;
    logic               issue, pop;

    logic [P_W-1:0]           mask, grp;
    logic [LAYER_W-1:0]       grp_sh;
    logic [ADDR_WIDTH-1:0]    addr_a, addr_b;
    logic [TW_ADDR_WIDTH-1:0] tw;

    addr_pair_t       head;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] inflight;

    // Pair p splits into group bits (above the len mask) and offset bits; the group bits move up one place.
    always_comb begin
        mask   = {P_W{1'b1}} >> layer_q;
        grp_sh = LAYER_W'(P_W) - layer_q;
        grp    = p_q >> grp_sh;
        addr_a = {p_q & ~mask, 1'b0} | {1'b0, p_q & mask};
        addr_b = addr_a | ({1'b0, mask} + ADDR_WIDTH'(1));
        tw     = (TW_ADDR_WIDTH'(1) << layer_q) | grp;
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        p_d     = p_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ISSUE;
                    layer_d = '0;
                    p_d     = '0;
                end
            end
            ISSUE: begin
                if (!fifo_full) begin
                    issue = 1'b1;
                    p_d   = p_q + P_W'(1);
                    if (p_q == '1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0) begin
                    if (layer_q == LAYER_W'(NUM_LAYERS - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        layer_d = layer_q + LAYER_W'(1);
                        p_d     = '0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            layer_q  <= '0;
            p_q      <= '0;
            bf_vld_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            p_q      <= p_d;
            bf_vld_q <= issue;
            err_q    <= err_q | (bf_valid_out_i && fifo_empty);
        end
    end

    ntt_addr_fifo #(.DEPTH(FIFO_DEPTH)) u_addr_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (issue),
        .push_dat_i ('{a: addr_a, b: addr_b}),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (inflight)
    );

    assign pop = bf_valid_out_i && !fifo_empty;

    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign bf_enable_o     = busy_o;
    assign rd_en_o         = issue;
    assign rd_addr_a_o     = issue ? addr_a : '0;
    assign rd_addr_b_o     = issue ? addr_b : '0;
    assign tw_addr_o       = issue ? tw : '0;
    assign bf_valid_in_o   = bf_vld_q;
    assign bf_a_o          = rd_data_a_i;
    assign bf_b_o          = rd_data_b_i;
    assign bf_twiddle_o    = tw_data_i;
    assign wr_en_o         = pop;
    assign wr_addr_a_o     = pop ? head.a : '0;
    assign wr_addr_b_o     = pop ? head.b : '0;
    assign wr_data_a_o     = pop ? bf_a_out_i : '0;
    assign wr_data_b_o     = pop ? bf_b_out_i : '0;
    assign err_underflow_o = err_q;

`ifdef NTT_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cycle_cnt_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            cycle_cnt_q <= '0;
        end else if (busy_o) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign cycle_count_o = cycle_cnt_q;
`endif
endmodule

// File: tb/tb_ntt_butterfly_scheduler.sv
// Bench: RAM, twiddle ROM and 7-cycle butterfly models around the scheduler; scoreboarded read/write order.
module tb_ntt_butterfly_scheduler;
    import ntt_pkg::*;

    localparam int DEPTH = 4;
    localparam int Q     = KYBER_Q;
    localparam int TOTAL = 896;
    localparam int LAT   = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n, start, busy, done, rd_en;
    logic [ADDR_WIDTH-1:0]    rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [DATA_WIDTH-1:0]    rd_data_a = '0, rd_data_b = '0, tw_data = '0;
    logic [TW_ADDR_WIDTH-1:0] tw_addr;
    logic                     bf_enable, bf_valid_in, bf_valid_out, wr_en, err_underflow;
    logic [DATA_WIDTH-1:0]    bf_a, bf_b, bf_twiddle, bf_a_out, bf_b_out, wr_data_a, wr_data_b;
    logic                     spur, load;
`ifdef NTT_CYCLE_COUNT_EN
    logic [31:0]              cycle_count;
`endif

    ntt_butterfly_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .rd_en_o(rd_en), .rd_addr_a_o(rd_addr_a), .rd_addr_b_o(rd_addr_b),
        .rd_data_a_i(rd_data_a), .rd_data_b_i(rd_data_b),
        .tw_addr_o(tw_addr), .tw_data_i(tw_data),
        .bf_enable_o(bf_enable), .bf_valid_in_o(bf_valid_in),
        .bf_a_o(bf_a), .bf_b_o(bf_b), .bf_twiddle_o(bf_twiddle),
        .bf_valid_out_i(bf_valid_out), .bf_a_out_i(bf_a_out), .bf_b_out_i(bf_b_out),
        .wr_en_o(wr_en), .wr_addr_a_o(wr_addr_a), .wr_addr_b_o(wr_addr_b),
        .wr_data_a_o(wr_data_a), .wr_data_b_o(wr_data_b),
        .err_underflow_o(err_underflow)
`ifdef NTT_CYCLE_COUNT_EN
        , .cycle_count_o(cycle_count)
`endif
    );

    function automatic int zeta(input int k);
        return (k * 1723 + 17) % Q;
    endfunction

    function automatic logic [23:0] bfly(input int a, input int b, input int w);
        int t;
        t = (w * b) % Q;
        return {12'((a + t) % Q), 12'((a - t + Q) % Q)};
    endfunction

    // ---------------- memory and butterfly models ----------------
    logic [DATA_WIDTH-1:0] ram [N];
    logic [DATA_WIDTH-1:0] init_mem [N];
    logic [DATA_WIDTH-1:0] gold [N];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) ram[i] <= init_mem[i];
        end else if (wr_en) begin
            ram[wr_addr_a] <= wr_data_a;
            ram[wr_addr_b] <= wr_data_b;
        end
        if (rd_en) begin
            rd_data_a <= ram[rd_addr_a];
            rd_data_b <= ram[rd_addr_b];
        end
        tw_data <= 12'(zeta(int'(tw_addr)));
    end

    logic                  pv [LAT];
    logic [DATA_WIDTH-1:0] pa [LAT];
    logic [DATA_WIDTH-1:0] pb [LAT];
    logic [23:0]           bres;
    assign bres = bfly(int'(bf_a), int'(bf_b), int'(bf_twiddle));

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
        end else if (bf_enable) begin
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
            pv[0] <= bf_valid_in;
            pa[0] <= bres[23:12];
            pb[0] <= bres[11:0];
        end
    end

    assign bf_valid_out = pv[LAT-1] | spur;
    assign bf_a_out     = pa[LAT-1];
    assign bf_b_out     = pb[LAT-1];

    // ---------------- scoreboard ----------------
    typedef struct {int a; int b; int tw; int layer;} rd_exp_t;
    typedef struct {int a; int b;} wr_exp_t;
    rd_exp_t rdq[$];
    wr_exp_t wrq[$];
    rd_exp_t re;
    wr_exp_t we;

    int passed = 0, total = 0;
    int iss_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0, max_infl = 0, infl = 0, rel = 0;
    int iss_base = 0, wr_base = 0, done_base = 0, busy_base = 0;

    int dir_idx [4] = '{0, 401, 768, 895};
    int dir_a   [4] = '{0, 33, 0, 253};
    int dir_b   [4] = '{128, 49, 2, 255};
    int dir_tw  [4] = '{1, 9, 64, 127};

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                rel = iss_cnt - iss_base;
                if (rdq.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    re = rdq.pop_front();
                    chk("rd_addr_a", int'(rd_addr_a), re.a);
                    chk("rd_addr_b", int'(rd_addr_b), re.b);
                    chk("tw_addr", int'(tw_addr), re.tw);
                    chk("layer_barrier", int'((wr_cnt - wr_base) >= re.layer * 128), 1);
                end
                for (int i = 0; i < 4; i++) begin
                    if (rel == dir_idx[i]) begin
                        chk("dir_rd_a", int'(rd_addr_a), dir_a[i]);
                        chk("dir_rd_b", int'(rd_addr_b), dir_b[i]);
                        chk("dir_tw", int'(tw_addr), dir_tw[i]);
                    end
                end
                chk("stall_at_depth", int'(((iss_cnt - iss_base) - (wr_cnt - wr_base)) < DEPTH), 1);
                iss_cnt++;
            end
            if (wr_en) begin
                if (wrq.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    we = wrq.pop_front();
                    chk("wr_addr_a", int'(wr_addr_a), we.a);
                    chk("wr_addr_b", int'(wr_addr_b), we.b);
                end
                wr_cnt++;
            end
            infl = (iss_cnt - iss_base) - (wr_cnt - wr_base);
            if (infl > max_infl) max_infl = infl;
            if (done) begin
                done_cnt++;
                chk("done_after_writes", wr_cnt - wr_base, TOTAL);
            end
            if (busy) busy_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic prep(input int seed);
        int k, layer;
        logic [23:0] r;
        for (int i = 0; i < N; i++) begin
            init_mem[i] = 12'((i * 73 + seed * 331) % Q);
            gold[i]     = init_mem[i];
        end
        rdq.delete();
        wrq.delete();
        k = 1;
        layer = 0;
        for (int len = 128; len >= 2; len = len >> 1) begin
            for (int st = 0; st < N; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    r = bfly(int'(gold[j]), int'(gold[j+len]), zeta(k));
                    gold[j]     = r[23:12];
                    gold[j+len] = r[11:0];
                    rdq.push_back('{a: j, b: j + len, tw: k, layer: layer});
                    wrq.push_back('{a: j, b: j + len});
                end
                k++;
            end
            layer++;
        end
        iss_base  = iss_cnt;
        wr_base   = wr_cnt;
        done_base = done_cnt;
        busy_base = busy_cnt;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt == done_base && t < 10000) begin
            @(posedge clk);
            t++;
        end
        chk("done_timeout", int'(t < 10000), 1);
        tick(3);
    endtask

    task automatic post_checks();
        int bad;
        bad = 0;
        chk("done_count", done_cnt - done_base, 1);
        chk("issue_count", iss_cnt - iss_base, TOTAL);
        chk("write_count", wr_cnt - wr_base, TOTAL);
        chk("rd_queue_left", rdq.size(), 0);
        chk("wr_queue_left", wrq.size(), 0);
        chk("busy_idle", int'(busy), 0);
        chk("err_underflow", int'(err_underflow), 0);
        for (int i = 0; i < N; i++) if (ram[i] !== gold[i]) bad++;
        chk("ram_vs_golden", bad, 0);
`ifdef NTT_CYCLE_COUNT_EN
        chk("cycle_count", int'(cycle_count), busy_cnt - busy_base);
`endif
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        start = 1'b0;
        spur  = 1'b0;
        load  = 1'b0;
        tick(3);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_err", int'(err_underflow), 0);
        chk("rst_rd_addr_b", int'(rd_addr_b), 0);
        chk("rst_bf_valid_in", int'(bf_valid_in), 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // run 1: full transform, with a stray start while busy
        prep(1);
        pulse_start();
        chk("busy_after_start", int'(busy), 1);
        chk("bf_enable_eq_busy", int'(bf_enable), 1);
        tick(50);
        pulse_start();
        wait_done();
        post_checks();

        // run 2: abort during layer 2
        prep(2);
        pulse_start();
        t = 0;
        while ((iss_cnt - iss_base) < 296 && t < 5000) begin
            tick(1);
            t++;
        end
        chk("reach_layer2", int'(t < 5000), 1);
        rst_n = 1'b0;
        tick(2);
        rdq.delete();
        wrq.delete();
        rst_n = 1'b1;
        tick(4);
        chk("abort_no_done", done_cnt - done_base, 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_err", int'(err_underflow), 0);

        // run 3: clean restart
        prep(3);
        pulse_start();
        wait_done();
        post_checks();
        chk("stall_reached_depth", max_infl, DEPTH);

        // spurious butterfly result while idle
        spur = 1'b1;
        @(negedge clk);
        chk("spur_no_wr", int'(wr_en), 0);
        tick(1);
        spur = 1'b0;
        tick(1);
        chk("err_sticky", int'(err_underflow), 1);
        tick(3);
        chk("err_still_set", int'(err_underflow), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
